circle_area_scheduler: RTL and testbench

Shares one FloatMultiplier_rounding instance between two radius requesters and sequences the two IEEE-754 single-precision passes (r*r, then r²*Pi) per request. A round-robin arbiter accepts one request at a time. Operands are muxed into the shared multiplier, and the intermediate square is registered between passes. The block replaces two parallel two-multiplier area calculators in the geometry datapath, using one multiplier instead of four.

---
 rtl/circle_area_scheduler_pkg.sv | 17 +
 rtl/FloatMultiplier_rounding.sv | 71 +++++++
 rtl/circle_area_scheduler.sv | 125 ++++++++++++
 tb/tb_circle_area_scheduler.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/circle_area_scheduler_pkg.sv
// Shared constants and state encoding for the circle area scheduler.
// Covers the float word width, the Pi operand and the FSM state type.
package circle_area_scheduler_pkg;

    localparam int CAS_DATA_W = 32;

    // Single-precision Pi, 3.14159
    localparam logic [CAS_DATA_W-1:0] CAS_PI = 32'h40490FD0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SQ   = 2'd1,
        ST_MPI  = 2'd2,
        ST_HOLD = 2'd3
    } cas_state_t;

endpackage

// File: rtl/FloatMultiplier_rounding.sv
// Combinational IEEE-754 single-precision multiplier, round-to-nearest-even.
// Ports: i_a, i_b operands; o_p product. Subnormal inputs and outputs flush to zero.
import circle_area_scheduler_pkg::*;

module FloatMultiplier_rounding (
    input  logic [CAS_DATA_W-1:0] i_a,
    input  logic [CAS_DATA_W-1:0] i_b,
    output logic [CAS_DATA_W-1:0] o_p
);

    logic        w_sign;
    logic [7:0]  w_ea;
    logic [7:0]  w_eb;
    logic        w_a_nan;
    logic        w_b_nan;
    logic        w_a_inf;
    logic        w_b_inf;
    logic        w_a_zero;
    logic        w_b_zero;
    logic [47:0] w_prod;
    logic [22:0] w_mant;
    logic        w_g;
    logic        w_s;
    logic [9:0]  w_exp;
    logic [23:0] w_rnd;
    logic [9:0]  w_exp_r;

    assign w_sign   = i_a[31] ^ i_b[31];
    assign w_ea     = i_a[30:23];
    assign w_eb     = i_b[30:23];
    assign w_a_nan  = (w_ea == 8'hFF) && (|i_a[22:0]);
    assign w_b_nan  = (w_eb == 8'hFF) && (|i_b[22:0]);
    assign w_a_inf  = (w_ea == 8'hFF) && !(|i_a[22:0]);
    assign w_b_inf  = (w_eb == 8'hFF) && !(|i_b[22:0]);
    assign w_a_zero = (w_ea == 8'h00);
    assign w_b_zero = (w_eb == 8'h00);

    assign w_prod = {24'b0, 1'b1, i_a[22:0]} * {24'b0, 1'b1, i_b[22:0]};

    always_comb begin
        // Product of two [1,2) mantissas lies in [1,4); bit 47 flags [2,4)
        if (w_prod[47]) begin
            w_mant = w_prod[46:24];
            w_g    = w_prod[23];
            w_s    = |w_prod[22:0];
        end else begin
            w_mant = w_prod[45:23];
            w_g    = w_prod[22];
            w_s    = |w_prod[21:0];
        end
        w_exp   = {2'b0, w_ea} + {2'b0, w_eb} - 10'd127
                + {9'b0, w_prod[47]};
        w_rnd   = {1'b0, w_mant} + {23'b0, w_g & (w_s | w_mant[0])};
        // Rounding carry-out leaves the low mantissa bits at zero
        w_exp_r = w_exp + {9'b0, w_rnd[23]};

        if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero))
            o_p = 32'h7FC00000;
        else if (w_a_inf || w_b_inf)
            o_p = {w_sign, 8'hFF, 23'b0};
        else if (w_a_zero || w_b_zero)
            o_p = {w_sign, 31'b0};
        else if (w_exp_r[9] || (w_exp_r == 10'd0))
            o_p = {w_sign, 31'b0};
        else if (w_exp_r >= 10'd255)
            o_p = {w_sign, 8'hFF, 23'b0};
        else
            o_p = {w_sign, w_exp_r[7:0], w_rnd[22:0]};
    end

endmodule

// File: rtl/circle_area_scheduler.sv
// Two-requester circle area unit: r*r then r^2*Pi on one shared multiplier.
// Ports: clk, rst (sync, active-low), in_valid/in_ready/radius0/radius1 requests;
// out_valid/out_ready/out_area/out_id result; busy status; done_count accepted results.
import circle_area_scheduler_pkg::*;

module circle_area_scheduler #(
    parameter int                DATA_W = CAS_DATA_W,
    parameter logic [DATA_W-1:0] PI     = CAS_PI,
    parameter int                CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        in_valid,
    output logic [1:0]        in_ready,
    input  logic [DATA_W-1:0] radius0,
    input  logic [DATA_W-1:0] radius1,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_area,
    output logic              out_id,
    output logic              busy,
    output logic [CNT_W-1:0]  done_count
);

    cas_state_t        r_state;
    logic              r_rr;
    logic              r_id;
    logic [DATA_W-1:0] r_radius;
    logic [DATA_W-1:0] r_sq;
    logic [DATA_W-1:0] r_area;
    logic              r_out_valid;
    logic              r_out_id;
    logic [CNT_W-1:0]  r_done;

    logic [1:0]        w_grant;
    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b;
    logic [DATA_W-1:0] w_prod;

    always_comb begin
        w_grant = 2'b00;
        if (r_state == ST_IDLE) begin
            unique case (in_valid)
                2'b01:   w_grant = 2'b01;
                2'b10:   w_grant = 2'b10;
                2'b11:   w_grant = r_rr ? 2'b10 : 2'b01;
                default: w_grant = 2'b00;
            endcase
        end
    end

    // Idle and hold feed zeros so the multiplier does not toggle
    always_comb begin
        w_a = '0;
        w_b = '0;
        unique case (r_state)
            ST_SQ: begin
                w_a = r_radius;
                w_b = r_radius;
            end
            ST_MPI: begin
                w_a = r_sq;
                w_b = PI;
            end
            default: ;
        endcase
    end

    FloatMultiplier_rounding u_fmul (
        .i_a (w_a),
        .i_b (w_b),
        .o_p (w_prod)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_rr        <= 1'b0;
            r_id        <= 1'b0;
            r_radius    <= '0;
            r_sq        <= '0;
            r_area      <= '0;
            r_out_valid <= 1'b0;
            r_out_id    <= 1'b0;
            r_done      <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (|w_grant) begin
                        r_radius <= w_grant[1] ? radius1 : radius0;
                        r_id     <= w_grant[1];
                        r_rr     <= ~w_grant[1];
                        r_state  <= ST_SQ;
                    end
                end
                ST_SQ: begin
                    r_sq    <= w_prod;
                    r_state <= ST_MPI;
                end
                ST_MPI: begin
                    r_area      <= w_prod;
                    r_out_valid <= 1'b1;
                    r_out_id    <= r_id;
                    r_state     <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_done      <= r_done + CNT_W'(1);
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready   = w_grant;
    assign out_valid  = r_out_valid;
    assign out_area   = r_area;
    assign out_id     = r_out_id;
    assign busy       = (r_state != ST_IDLE);
    assign done_count = r_done;

endmodule

// File: tb/tb_circle_area_scheduler.sv
// Directed bench for circle_area_scheduler.
// Small done counter so the wrap is reached in a few requests.
module tb_circle_area_scheduler;

    localparam int CW = 2;

    logic          clk;
    logic          rst;
    logic [1:0]    in_valid;
    logic [1:0]    in_ready;
    logic [31:0]   radius0;
    logic [31:0]   radius1;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_area;
    logic          out_id;
    logic          busy;
    logic [CW-1:0] done_count;

    int            n_checks;
    int            n_fail;
    logic [CW-1:0] exp_done;
    logic          exp_id;
    logic [31:0]   held;

    circle_area_scheduler #(
        .CNT_W (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .radius0    (radius0),
        .radius1    (radius1),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_area   (out_area),
        .out_id     (out_id),
        .busy       (busy),
        .done_count (done_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the idle negedge
    task automatic run_one(input string tag, input logic [1:0] vld,
                           input logic [31:0] r, input logic [31:0] area,
                           input logic id);
        if (vld[0]) radius0 = r;
        if (vld[1]) radius1 = r;
        in_valid  = vld;
        out_ready = 1'b1;
        #1;
        chk({tag, " in_ready"}, 32'(in_ready), id ? 32'd2 : 32'd1);
        @(negedge clk);
        in_valid = 2'b00;
        chk({tag, " busy"}, 32'(busy), 32'd1);
        chk({tag, " early valid"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        chk({tag, " valid T+1"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        chk({tag, " valid T+2"}, 32'(out_valid), 32'd1);
        chk({tag, " area"}, out_area, area);
        chk({tag, " id"}, 32'(out_id), 32'(id));
        exp_done = exp_done + 1'b1;
        @(negedge clk);
        chk({tag, " valid drop"}, 32'(out_valid), 32'd0);
        chk({tag, " done"}, 32'(done_count), 32'(exp_done));
        chk({tag, " idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        exp_done  = '0;
        rst       = 1'b0;
        in_valid  = 2'b00;
        radius0   = '0;
        radius1   = '0;
        out_ready = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst valid", 32'(out_valid), 32'd0);
        chk("rst area", out_area, 32'h0);
        chk("rst id", 32'(out_id), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done_count), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // 2.0 -> 4.0 * Pi
        run_one("single", 2'b01, 32'h40000000, 32'h41490FD0, 1'b0);

        // Requester 0 was just served, so alternation starts with 1
        radius0   = 32'h3F800000;
        radius1   = 32'h3F000000;
        in_valid  = 2'b11;
        out_ready = 1'b1;
        exp_id    = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr grant", 32'(in_ready), exp_id ? 32'd2 : 32'd1);
            repeat (3) @(negedge clk);
            chk("rr valid", 32'(out_valid), 32'd1);
            chk("rr id", 32'(out_id), 32'(exp_id));
            chk("rr area", out_area,
                exp_id ? 32'h3F490FD0 : 32'h40490FD0);
            exp_done = exp_done + 1'b1;
            @(negedge clk);
            if (k == 3) in_valid = 2'b00;
            chk("rr done", 32'(done_count), 32'(exp_done));
            chk("rr idle", 32'(busy), 32'd0);
            exp_id = ~exp_id;
        end

        // Backpressure with requester 1 waiting
        out_ready = 1'b0;
        radius0   = 32'h40000000;
        in_valid  = 2'b01;
        @(negedge clk);
        radius1  = 32'h3F000000;
        in_valid = 2'b10;
        chk("bp ready sq", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("bp ready mpi", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("bp valid", 32'(out_valid), 32'd1);
        chk("bp area", out_area, 32'h41490FD0);
        chk("bp id", 32'(out_id), 32'd0);
        held = out_area;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp stable", out_area, held);
            chk("bp hold valid", 32'(out_valid), 32'd1);
            chk("bp hold ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        exp_done  = exp_done + 1'b1;
        @(negedge clk);
        chk("bp release", 32'(out_valid), 32'd0);
        chk("bp done", 32'(done_count), 32'(exp_done));
        chk("bp grant 1", 32'(in_ready), 32'd2);
        @(negedge clk);
        in_valid = 2'b00;
        chk("bp accept", 32'(busy), 32'd1);
        repeat (2) @(negedge clk);
        chk("bp r1 area", out_area, 32'h3F490FD0);
        chk("bp r1 id", 32'(out_id), 32'd1);
        exp_done = exp_done + 1'b1;
        @(negedge clk);
        chk("bp r1 done", 32'(done_count), 32'(exp_done));

        // Reset while in MPI discards the result
        radius0  = 32'h3F800000;
        in_valid = 2'b01;
        @(negedge clk);
        in_valid = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst      = 1'b1;
        exp_done = '0;
        chk("mid rst valid", 32'(out_valid), 32'd0);
        chk("mid rst busy", 32'(busy), 32'd0);
        chk("mid rst done", 32'(done_count), 32'd0);
        chk("mid rst area", out_area, 32'h0);
        repeat (2) @(negedge clk);
        chk("mid rst no out", 32'(out_valid), 32'd0);

        // Pointer is back at 0 after reset
        radius1 = 32'h3F000000;
        run_one("post rst rr", 2'b11, 32'h3F800000, 32'h40490FD0, 1'b0);
        run_one("zero", 2'b01, 32'h00000000, 32'h00000000, 1'b0);
        run_one("overflow", 2'b10, 32'h7F000000, 32'h7F800000, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
